// File: rtl/negator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : negator_pkg
// Purpose  : Shared default sizing for the pipelined lane negator.
// Revision : 1.0
// ============================================================================
package negator_pkg;

  localparam int INTEGER_WIDTH = 32;
  localparam int LANES         = 2;
  localparam int DATA_WIDTH    = LANES * INTEGER_WIDTH;

endpackage : negator_pkg
`default_nettype wire

// File: rtl/negator_lane.sv
`default_nettype none
// ============================================================================
// Module   : negator_lane
// Purpose  : Combinational two's-complement negation of one WIDTH-bit lane.
// Revision : 1.0
// ============================================================================
module negator_lane
  import negator_pkg::*;
#(
  parameter int WIDTH = INTEGER_WIDTH
) (
  input  logic [WIDTH-1:0] lane_i,
  output logic [WIDTH-1:0] lane_o
);

  // Wraps modulo 2^WIDTH, so the most-negative value maps to itself.
  assign lane_o = ~lane_i + WIDTH'(1);

endmodule : negator_lane
`default_nettype wire

// File: rtl/pipelined_negator.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_negator
// Purpose  : Two-stage valid/ready pipeline negating N packed signed lanes.
// Revision : 1.0
// ============================================================================
module pipelined_negator #(
  parameter  int WIDTH_IN_NUM_OF_FULL_INTEGER = negator_pkg::LANES,
  parameter  int INTEGER_WIDTH                = negator_pkg::INTEGER_WIDTH,
  localparam int DATA_W = WIDTH_IN_NUM_OF_FULL_INTEGER * INTEGER_WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              input_valid,
  output logic              input_ready,
  input  logic [DATA_W-1:0] input_data,
  output logic              output_valid,
  input  logic              output_ready,
  output logic [DATA_W-1:0] output_data
);

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;
  logic [DATA_W-1:0] s2_data_q,  s2_data_d;
  logic [DATA_W-1:0] w_neg;
  logic              w_s1_free, w_s2_free, w_in_xfer, w_s1_adv;

  // Free flags chain backwards so a draining S2 lets S1 and the input move in the same cycle.
  assign w_s2_free = !s2_valid_q || output_ready;
  assign w_s1_free = !s1_valid_q || w_s2_free;
  assign w_s1_adv  = s1_valid_q && w_s2_free;
  assign w_in_xfer = input_valid && w_s1_free;

  generate
    for (genvar g = 0; g < WIDTH_IN_NUM_OF_FULL_INTEGER; g++) begin : g_lane
      negator_lane #(
        .WIDTH (INTEGER_WIDTH)
      ) u_lane (
        .lane_i (s1_data_q[g*INTEGER_WIDTH +: INTEGER_WIDTH]),
        .lane_o (w_neg[g*INTEGER_WIDTH +: INTEGER_WIDTH])
      );
    end
  endgenerate

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;

    if (w_in_xfer) begin
      s1_valid_d = 1'b1;
      s1_data_d  = input_data;
    end else if (w_s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (w_s1_adv) begin
      s2_valid_d = 1'b1;
      s2_data_d  = w_neg;
    end else if (output_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_data_q  <= s1_data_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign input_ready  = w_s1_free;
  assign output_valid = s2_valid_q;
  assign output_data  = s2_data_q;

endmodule : pipelined_negator
`default_nettype wire

// File: tb/tb_pipelined_negator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_negator
// Purpose  : Directed and randomized self-checking bench for pipelined_negator.
// Revision : 1.0
// ============================================================================
module tb_pipelined_negator;

  logic        clock        = 1'b0;
  logic        reset        = 1'b0;
  logic        input_valid  = 1'b0;
  logic        output_ready = 1'b0;
  logic [63:0] input_data   = '0;
  logic        input_ready;
  logic        output_valid;
  logic [63:0] output_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  pipelined_negator #(
    .WIDTH_IN_NUM_OF_FULL_INTEGER (2),
    .INTEGER_WIDTH                (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] neg_word(input logic [63:0] x);
    logic [31:0] lo, hi;
    lo = x[31:0];
    hi = x[63:32];
    return {-hi, -lo};
  endfunction

  // Drive one cycle's inputs at the falling edge and report what the next rising edge will transfer.
  task automatic cycle(input logic iv, input logic [63:0] id, input logic ordy,
                       output logic acc, output logic outx, output logic [63:0] od);
    @(negedge clock);
    input_valid  = iv;
    input_data   = id;
    output_ready = ordy;
    #1;
    acc  = iv && input_ready;
    outx = output_valid && ordy;
    od   = output_data;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (output_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", output_valid); end
    n_cmp++; if (output_data !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", output_data); end
    n_cmp++; if (input_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", input_ready); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic acc, ox;
    logic [63:0] od;
    cycle(1'b1, 64'h00000001_00000005, 1'b1, acc, ox, od);
    n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL single_accept: got %b expected 1", acc); end
    cycle(1'b0, 64'h0, 1'b1, acc, ox, od);
    n_cmp++; if (ox !== 1'b0) begin n_err++; $display("FAIL single_early: got valid %b expected 0", ox); end
    cycle(1'b0, 64'h0, 1'b1, acc, ox, od);
    n_cmp++; if (ox !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", ox); end
    n_cmp++; if (od !== 64'hFFFFFFFF_FFFFFFFB) begin n_err++; $display("FAIL single_data: got %h expected FFFFFFFFFFFFFFFB", od); end
    cycle(1'b0, 64'h0, 1'b1, acc, ox, od);
    n_cmp++; if (ox !== 1'b0) begin n_err++; $display("FAIL single_once: got valid %b expected 0", ox); end
  endtask

  task automatic test_edge_lanes();
    logic acc, ox, ex;
    logic [63:0] od, id, ed;
    for (int c = 0; c < 6; c++) begin
      id = (c == 0) ? 64'h80000000_00000000 : 64'h7FFFFFFF_FFFFFFFF;
      cycle(c < 2, id, 1'b1, acc, ox, od);
      if (c < 2) begin
        n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL edge_accept[%0d]: got %b expected 1", c, acc); end
      end
      ex = (c == 2) || (c == 3);
      ed = (c == 2) ? 64'h80000000_00000000 : 64'h80000001_00000001;
      n_cmp++; if (ox !== ex) begin n_err++; $display("FAIL edge_valid[%0d]: got %b expected %b", c, ox, ex); end
      if (ex) begin
        n_cmp++; if (od !== ed) begin n_err++; $display("FAIL edge_data[%0d]: got %h expected %h", c, od, ed); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, ox;
    logic [63:0] od, ed;
    logic [31:0] k;
    for (int c = 0; c < 11; c++) begin
      k = 32'(c + 1);
      cycle(c < 8, {k, k}, 1'b1, acc, ox, od);
      if (c < 8) begin
        n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL b2b_accept[%0d]: got %b expected 1", c, acc); end
      end
      if (c >= 2 && c <= 9) begin
        k  = 32'(c - 1);
        ed = {-k, -k};
        n_cmp++; if (ox !== 1'b1 || od !== ed) begin n_err++; $display("FAIL b2b_out[%0d]: got valid %b data %h expected 1 %h", c, ox, od, ed); end
      end else begin
        n_cmp++; if (ox !== 1'b0) begin n_err++; $display("FAIL b2b_gap[%0d]: got valid %b expected 0", c, ox); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic acc, ox;
    logic [63:0] od, ed;
    logic [63:0] w[4];
    int sent, got;
    w[0] = 64'h00000010_00000020;
    w[1] = 64'hFFFFFFFF_00000003;
    w[2] = 64'h12345678_9ABCDEF0;
    w[3] = 64'h00000000_00000001;
    sent = 0;
    got  = 0;
    exp_q.delete();
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, w[sent], 1'b0, acc, ox, od);
      if (acc) begin exp_q.push_back(neg_word(w[sent])); sent++; end
      if (c >= 2) begin
        n_cmp++; if (output_valid !== 1'b1 || od !== 64'hFFFFFFF0_FFFFFFE0) begin n_err++; $display("FAIL bp_hold[%0d]: got valid %b data %h expected 1 FFFFFFF0FFFFFFE0", c, output_valid, od); end
      end
    end
    n_cmp++; if (sent != 2) begin n_err++; $display("FAIL bp_accepts: got %0d expected 2", sent); end
    n_cmp++; if (input_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b expected 0", input_ready); end
    for (int c = 0; c < 20 && (sent < 4 || exp_q.size() != 0); c++) begin
      cycle(sent < 4, (sent < 4) ? w[sent] : 64'h0, 1'b1, acc, ox, od);
      if (ox) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL bp_extra: got %h expected nothing", od);
        end else begin
          ed = exp_q.pop_front();
          n_cmp++; if (od !== ed) begin n_err++; $display("FAIL bp_drain[%0d]: got %h expected %h", got, od, ed); end
          got++;
        end
      end
      if (acc) begin exp_q.push_back(neg_word(w[sent])); sent++; end
    end
    n_cmp++; if (got != 4) begin n_err++; $display("FAIL bp_count: got %0d expected 4", got); end
    cycle(1'b0, 64'h0, 1'b1, acc, ox, od);
    n_cmp++; if (ox !== 1'b0) begin n_err++; $display("FAIL bp_dup: got valid %b expected 0", ox); end
  endtask

  task automatic test_reset_midstream();
    logic acc, ox;
    logic [63:0] od;
    cycle(1'b1, 64'h11111111_22222222, 1'b0, acc, ox, od);
    cycle(1'b1, 64'h33333333_44444444, 1'b0, acc, ox, od);
    cycle(1'b0, 64'h0, 1'b0, acc, ox, od);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (output_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b expected 0", output_valid); end
    n_cmp++; if (output_data !== 64'h0) begin n_err++; $display("FAIL rst_mid_data: got %h expected 0", output_data); end
    n_cmp++; if (input_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b expected 1", input_ready); end
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 64'h0, 1'b1, acc, ox, od);
      n_cmp++; if (ox !== 1'b0) begin n_err++; $display("FAIL rst_stale[%0d]: got valid %b data %h expected 0", c, ox, od); end
    end
    cycle(1'b1, 64'h00000002_FFFFFFFF, 1'b1, acc, ox, od);
    cycle(1'b0, 64'h0, 1'b1, acc, ox, od);
    cycle(1'b0, 64'h0, 1'b1, acc, ox, od);
    n_cmp++; if (ox !== 1'b1 || od !== 64'hFFFFFFFE_00000001) begin n_err++; $display("FAIL rst_after: got valid %b data %h expected 1 FFFFFFFE00000001", ox, od); end
  endtask

  task automatic test_random();
    logic acc, ox, iv, ordy, prev_stall;
    logic [63:0] od, id, ed, prev_data;
    int sent, got, cyc;
    sent = 0;
    got  = 0;
    cyc  = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    exp_q.delete();
    while (got < 1000 && cyc < 20000) begin
      iv   = (sent < 1000) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       id = 64'h80000000_7FFFFFFF;
        1:       id = 64'h00000000_80000000;
        default: id = {$urandom, $urandom};
      endcase
      cycle(iv, id, ordy, acc, ox, od);
      if (prev_stall) begin
        n_cmp++; if (output_valid !== 1'b1 || od !== prev_data) begin n_err++; $display("FAIL rnd_stall: got valid %b data %h expected 1 %h", output_valid, od, prev_data); end
      end
      if (ox) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL rnd_extra: got %h expected nothing", od);
        end else begin
          ed = exp_q.pop_front();
          n_cmp++; if (od !== ed) begin n_err++; $display("FAIL rnd_data[%0d]: got %h expected %h", got, od, ed); end
        end
        got++;
      end
      if (acc) begin exp_q.push_back(neg_word(id)); sent++; end
      prev_stall = output_valid && !ordy;
      prev_data  = od;
      cyc++;
    end
    n_cmp++; if (got != 1000 || exp_q.size() != 0) begin n_err++; $display("FAIL rnd_count: got %0d outputs %0d pending expected 1000 0", got, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_edge_lanes();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pipelined_negator
`default_nettype wire
